// File: rtl/uart_event_sender.sv
// Latches game events with latest-value-wins coalescing, picks one by fixed priority
// (OVER > START > MOLE > SCORE) and streams its ASCII message to uart_tx byte by byte.
module uart_event_sender #(
   parameter logic [7:0] TERMINATOR = 8'h0A,
   parameter logic       SEND_SCORE = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start_evt,
   input  logic       over_evt,
   input  logic       mole_valid,
   input  logic [2:0] mole_index,
   input  logic       score_valid,
   input  logic [5:0] score,
   input  logic       tx_busy,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic       idle,
   output logic [7:0] drop_count
);

   typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_HI, WAIT_LO} state_t;

   state_t     state;
   logic       pend_over, pend_start, pend_mole, pend_score;
   logic [2:0] mole_q;
   logic [5:0] score_q;
   logic [7:0] msg_buf [4];
   logic [2:0] msg_len;
   logic [1:0] ptr;

   logic       score_hit;
   logic       sel_over, sel_start, sel_mole, sel_score;
   logic       over_n, start_n, mole_n, score_n;
   logic       mole_drop, score_drop;
   logic [8:0] drop_sum;
   logic [7:0] drop_n;
   logic       any_pend, last_byte, to_idle, idle_n;
   logic [2:0] tens;
   logic [3:0] ones;
   logic [7:0] mole_char;
   logic [7:0] msg [4];
   logic [2:0] new_len;

   assign score_hit = score_valid & SEND_SCORE;
   assign any_pend  = pend_over | pend_start | pend_mole | pend_score;

   assign sel_over  = pend_over;
   assign sel_start = ~pend_over & pend_start;
   assign sel_mole  = ~pend_over & ~pend_start & pend_mole;
   assign sel_score = ~pend_over & ~pend_start & ~pend_mole & pend_score;

   // The selected flag clears on the load edge; a pulse on that same edge re-arms it without a drop.
   always_comb begin
      over_n  = (pend_over  & ~((state == LOAD) & sel_over))  | over_evt;
      start_n = (pend_start & ~((state == LOAD) & sel_start)) | start_evt;
      mole_n  = (pend_mole  & ~((state == LOAD) & sel_mole))  | mole_valid;
      score_n = (pend_score & ~((state == LOAD) & sel_score)) | score_hit;
      mole_drop  = mole_valid & pend_mole  & ~((state == LOAD) & sel_mole);
      score_drop = score_hit  & pend_score & ~((state == LOAD) & sel_score);
      drop_sum = {1'b0, drop_count} + 9'(mole_drop) + 9'(score_drop);
      drop_n   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
   end

   assign last_byte = ({1'b0, ptr} == (msg_len - 3'd1));
   assign to_idle   = ((state == IDLE) & ~any_pend) |
                      ((state == WAIT_LO) & ~tx_busy & last_byte);
   assign idle_n    = to_idle & ~(over_n | start_n | mole_n | score_n);

   always_comb begin
      tens = '0;
      for (int unsigned t = 1; t <= 6; t++)
         if (score_q >= 6'(t * 10)) tens = 3'(t);
      ones = 4'(score_q - 6'(tens) * 6'd10);
   end

   assign mole_char = (mole_q > 3'd4) ? 8'h34 : (8'h30 + {5'b0, mole_q});

   always_comb begin
      msg     = '{default: '0};
      new_len = 3'd2;
      if (pend_over) begin
         msg[0] = 8'h47;
         msg[1] = TERMINATOR;
      end else if (pend_start) begin
         msg[0] = 8'h53;
         msg[1] = TERMINATOR;
      end else if (pend_mole) begin
         msg[0]  = 8'h4D;
         msg[1]  = mole_char;
         msg[2]  = TERMINATOR;
         new_len = 3'd3;
      end else begin
         msg[0]  = 8'h50;
         msg[1]  = 8'h30 + {5'b0, tens};
         msg[2]  = 8'h30 + {4'b0, ones};
         msg[3]  = TERMINATOR;
         new_len = 3'd4;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         pend_over  <= '0;
         pend_start <= '0;
         pend_mole  <= '0;
         pend_score <= '0;
         mole_q     <= '0;
         score_q    <= '0;
         msg_buf    <= '{default: '0};
         msg_len    <= '0;
         ptr        <= '0;
         tx_start   <= '0;
         tx_data    <= '0;
         idle       <= '1;
         drop_count <= '0;
      end else begin
         pend_over  <= over_n;
         pend_start <= start_n;
         pend_mole  <= mole_n;
         pend_score <= score_n;
         if (mole_valid) mole_q  <= mole_index;
         if (score_hit)  score_q <= score;
         drop_count <= drop_n;
         idle       <= idle_n;
         tx_start   <= '0;
         case (state)
            IDLE: if (any_pend) state <= LOAD;
            LOAD: begin
               msg_buf <= msg;
               msg_len <= new_len;
               ptr     <= '0;
               state   <= SEND;
            end
            SEND: begin
               tx_start <= '1;
               tx_data  <= msg_buf[ptr];
               state    <= WAIT_HI;
            end
            WAIT_HI: if (tx_busy) state <= WAIT_LO;
            WAIT_LO: begin
               if (!tx_busy) begin
                  if (last_byte) begin
                     state <= IDLE;
                  end else begin
                     ptr   <= ptr + 2'd1;
                     state <= SEND;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_event_sender.sv
// Randomized self-checking bench for uart_event_sender with a uart_tx busy model and
// a message-level reference model (pending flags, priority order, ASCII formatting).
module tb_uart_event_sender;

   logic       clock = 1'b0;
   logic       reset;
   logic       start_evt, over_evt, mole_valid, score_valid;
   logic [2:0] mole_index;
   logic [5:0] score;
   logic       tx_busy;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       idle;
   logic [7:0] drop_count;

   logic       ns_tx_start, ns_idle;
   logic [7:0] ns_tx_data, ns_drop;
   logic       zero_bit = 1'b0;
   logic [2:0] zero3 = 3'd0;

   always #5 clock = ~clock;

   uart_event_sender dut (
      .clock(clock), .reset(reset), .start_evt(start_evt), .over_evt(over_evt),
      .mole_valid(mole_valid), .mole_index(mole_index), .score_valid(score_valid),
      .score(score), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
      .idle(idle), .drop_count(drop_count)
   );

   uart_event_sender #(.SEND_SCORE(1'b0)) dut_ns (
      .clock(clock), .reset(reset), .start_evt(zero_bit), .over_evt(zero_bit),
      .mole_valid(zero_bit), .mole_index(zero3), .score_valid(score_valid),
      .score(score), .tx_busy(zero_bit), .tx_start(ns_tx_start), .tx_data(ns_tx_data),
      .idle(ns_idle), .drop_count(ns_drop)
   );

   // uart_tx stand-in: busy rises the cycle after tx_start and lasts busy_len cycles
   int unsigned busy_len = 20;
   int unsigned busy_cnt = 0;
   logic        busy_q = 1'b0;
   logic        hold_busy = 1'b0;
   assign tx_busy = busy_q | hold_busy;

   always @(posedge clock) begin
      if (tx_start) begin
         busy_q   <= 1'b1;
         busy_cnt <= busy_len - 1;
      end else if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 1;
      end else begin
         busy_q <= 1'b0;
      end
   end

   logic [7:0]  rx_q[$];
   logic [7:0]  exp_q[$];
   int unsigned start_pulses = 0;
   int unsigned ns_pulses = 0;
   int unsigned proto_err = 0;
   logic        prev_start = 1'b0;

   always @(posedge clock) begin
      if (tx_start) begin
         rx_q.push_back(tx_data);
         start_pulses++;
         if (tx_busy || prev_start) proto_err++;
      end
      prev_start = tx_start;
      if (ns_tx_start) ns_pulses++;
   end

   int unsigned n_tests = 0;
   int unsigned n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: 0=OVER 1=START 2=MOLE 3=SCORE, index order is priority order
   bit [3:0]    pend = '0;
   int unsigned m_idx = 0;
   int unsigned m_score = 0;
   int unsigned model_drop = 0;

   function automatic void emit(input int t);
      case (t)
         0: exp_q.push_back(8'h47);
         1: exp_q.push_back(8'h53);
         2: begin
            exp_q.push_back(8'h4D);
            exp_q.push_back(8'h30 + 8'((m_idx > 4) ? 4 : m_idx));
         end
         default: begin
            exp_q.push_back(8'h50);
            exp_q.push_back(8'h30 + 8'(m_score / 10));
            exp_q.push_back(8'h30 + 8'(m_score % 10));
         end
      endcase
      exp_q.push_back(8'h0A);
   endfunction

   function automatic void model_pulse(input int t, input int unsigned val);
      if (pend[t] && t >= 2 && model_drop < 255) model_drop++;
      pend[t] = 1'b1;
      if (t == 2) m_idx = val;
      if (t == 3) m_score = val;
   endfunction

   function automatic void model_load_first();
      for (int t = 0; t < 4; t++)
         if (pend[t]) begin
            emit(t);
            pend[t] = 1'b0;
            return;
         end
   endfunction

   function automatic void model_flush();
      for (int i = 0; i < 4; i++) model_load_first();
   endfunction

   task automatic fire(input logic o, input logic s, input logic m, input logic [2:0] mi,
                       input logic sc, input logic [5:0] sv);
      over_evt = o; start_evt = s; mole_valid = m; mole_index = mi;
      score_valid = sc; score = sv;
      if (o)  model_pulse(0, 0);
      if (s)  model_pulse(1, 0);
      if (m)  model_pulse(2, mi);
      if (sc) model_pulse(3, sv);
      @(negedge clock);
      over_evt = 1'b0; start_evt = 1'b0; mole_valid = 1'b0; score_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int unsigned n = 0;
      while (!idle && n < 2000) begin
         @(negedge clock);
         n++;
      end
      check({tag, "_idle_timeout"}, 32'(idle), 32'd1);
   endtask

   task automatic wait_rx(input string tag, input int unsigned cnt);
      int unsigned n = 0;
      while (rx_q.size() < cnt && n < 2000) begin
         @(negedge clock);
         n++;
      end
      check({tag, "_rx_timeout"}, 32'(rx_q.size() >= cnt), 32'd1);
   endtask

   task automatic compare_msgs(input string tag);
      check({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
         check({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
      rx_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned lat, p0, n, mask, k;
      reset = 1'b1;
      over_evt = 1'b0; start_evt = 1'b0; mole_valid = 1'b0; score_valid = 1'b0;
      mole_index = '0; score = '0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("rst_idle", 32'(idle), 32'd1);
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_drop", 32'(drop_count), 32'd0);

      // single mole message with latency from event edge to tx_start
      p0 = start_pulses;
      fire(0, 0, 1, 3'd2, 0, 0);
      lat = 0;
      while (!tx_start && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      check("mole_latency", lat, 3);
      model_flush();
      wait_idle("mole");
      check("mole_starts", start_pulses - p0, 3);
      compare_msgs("mole");
      check("mole_idle", 32'(idle), 32'd1);

      fire(0, 0, 0, 0, 1, 6'd47);
      model_flush();
      wait_idle("score47");
      compare_msgs("score47");
      fire(0, 0, 0, 0, 1, 6'd0);
      model_flush();
      wait_idle("score0");
      compare_msgs("score0");

      fire(1, 1, 1, 3'd1, 1, 6'd5);
      model_flush();
      wait_idle("all4");
      compare_msgs("all4");

      // mole pulses during START; the last lands on the MOLE load edge
      fire(0, 1, 0, 0, 0, 0);
      wait_rx("coal", 1);
      fire(0, 0, 1, 3'd0, 0, 0);
      repeat (3) @(negedge clock);
      fire(0, 0, 1, 3'd3, 0, 0);
      wait_rx("coal", 2);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (tx_busy && n < 100);
      repeat (2) @(negedge clock);
      model_flush();
      fire(0, 0, 1, 3'd4, 0, 0);
      model_flush();
      wait_idle("coal");
      compare_msgs("coal");
      check("coal_drop", 32'(drop_count), model_drop);

      // random bursts plus mid-message coalescing
      for (int it = 0; it < 12; it++) begin
         busy_len = $urandom_range(8, 20);
         mask = $urandom_range(1, 15);
         fire(mask[0], mask[1], mask[2], 3'($urandom_range(7)), mask[3], 6'($urandom_range(63)));
         model_load_first();
         wait_rx("rand", 1);
         k = $urandom_range(0, 4);
         for (int j = 0; j < int'(k); j++) begin
            if ($urandom_range(1) == 0) fire(0, 0, 1, 3'($urandom_range(7)), 0, 0);
            else fire(0, 0, 0, 0, 1, 6'($urandom_range(63)));
            if ($urandom_range(1) == 1) @(negedge clock);
         end
         model_flush();
         wait_idle("rand");
         compare_msgs("rand");
         check("rand_drop", 32'(drop_count), model_drop);
      end
      busy_len = 20;

      // reset during WAIT_LO of the second SCORE byte, with events pending
      fire(0, 0, 0, 0, 1, 6'd33);
      wait_rx("rstmid", 2);
      fire(0, 1, 1, 3'd2, 0, 0);
      repeat (4) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      pend = '0;
      model_drop = 0;
      rx_q.delete();
      exp_q.delete();
      check("rstmid_tx_start", 32'(tx_start), 32'd0);
      check("rstmid_tx_data", 32'(tx_data), 32'd0);
      check("rstmid_idle", 32'(idle), 32'd1);
      check("rstmid_drop", 32'(drop_count), 32'd0);
      p0 = start_pulses;
      repeat (40) @(negedge clock);
      check("rstmid_quiet", start_pulses - p0, 0);
      fire(0, 1, 0, 0, 0, 0);
      model_flush();
      wait_idle("rststart");
      compare_msgs("rststart");

      // drop counter saturation while the link is held busy
      fire(0, 1, 0, 0, 0, 0);
      model_load_first();
      wait_rx("sat", 1);
      hold_busy = 1'b1;
      for (int j = 0; j < 300; j++) fire(0, 0, 1, 3'($urandom_range(7)), 0, 0);
      @(negedge clock);
      check("sat_drop", 32'(drop_count), 32'd255);
      check("sat_model", 32'(drop_count), model_drop);
      check("sat_not_idle", 32'(idle), 32'd0);
      hold_busy = 1'b0;
      model_flush();
      wait_idle("sat");
      compare_msgs("sat");

      check("proto", proto_err, 0);
      check("ns_starts", ns_pulses, 0);
      check("ns_drop", 32'(ns_drop), 32'd0);
      check("ns_idle", 32'(ns_idle), 32'd1);
      check("ns_tx_data", 32'(ns_tx_data), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
